atom_mem_arbiter: RTL
=====================

// Module: atom_mem_arbiter
// PURPOSE
//  Sits between AtomFpga_Core's external bus and the single-port 192 KB spram.
//  Shares the RAM port between the core (absolute priority, zero added latency) and
//  HPS ioctl download writes into utility slot 7 (0x17000-0x17FFF). Download bytes are
//  buffered in a small FIFO and written in cycles where the core is not addressing memory.
//  Also write-protects ROM pages against core writes.
// PARAMETERS
//  FIFO_DEPTH  4        download byte FIFO entries (power of 2, >=2)
//  SLOT_BASE   18'h17000 spram address of download byte 0
//  SLOT_SIZE   4096     bytes accepted; offsets >= SLOT_SIZE are rejected
// PORTS
//  clk_sys      in   1   system clock (clk_32); everything on its rising edge
//  reset        in   1   synchronous, active-high
//  cpu_ce       in   1   core memory cycle strobe (ExternCE)
//  cpu_we       in   1   core write request (ExternWE)
//  cpu_addr     in   18  core address (ExternA)
//  cpu_wdata    in   8   core write data (ExternDin)
//  cpu_rdata    out  8   read data to core (ExternDout)
//  wp_en        in   1   1 = suppress core writes to ROM pages
//  dl_active    in   1   ioctl_download qualified by ioctl_index
//  dl_wr        in   1   ioctl_wr, one-cycle byte strobe
//  dl_addr      in   25  ioctl_addr (byte offset)
//  dl_data      in   8   ioctl_dout
//  mem_addr     out  18  spram address
//  mem_din      out  8   spram write data
//  mem_we       out  1   spram write enable
//  mem_q        in   8   spram read data
//  dl_busy      out  1   download in progress or FIFO non-empty
//  dl_done      out  1   one-cycle pulse when download finished and FIFO drained
//  dl_overflow  out  1   sticky: byte dropped because FIFO full
//  dl_oor       out  1   sticky: byte dropped because offset >= SLOT_SIZE
//  dl_count     out  13  bytes committed to spram this download
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE, dl_busy/dl_done/dl_overflow/dl_oor=0, dl_count=0.
//   Reset mid-download discards buffered bytes; no partial write is issued.
//  Port mux (combinational): cpu_ce=1 -> mem_addr=cpu_addr, mem_din=cpu_wdata,
//   mem_we=cpu_we & ~(wp_en & rom_page(cpu_addr[17:12])). Else if pop -> FIFO head
//   (addr=SLOT_BASE+offset, we=1). Else mem_addr=cpu_addr, mem_we=0.
//  rom_page: pages 0x0C-0x16, 0x18-0x1F, 0x26-0x27, 0x2A, 0x2C-0x2F. Page 0x17 writable.
//  cpu_rdata = mem_q always (spram latency unchanged, one clock).
//  Push: dl_wr & state LOAD & offset<SLOT_SIZE & (~full | pop). Full and no pop -> drop,
//   set dl_overflow. offset>=SLOT_SIZE -> drop, set dl_oor, no push.
//  Pop: ~cpu_ce & ~empty & state in {LOAD,FLUSH}. Each pop increments dl_count
//   (saturates at 4096). Push+pop same cycle: both occur, occupancy unchanged.
//  FSM:
//   IDLE : dl_active rise -> LOAD; clear dl_overflow, dl_oor, dl_count.
//   LOAD : dl_active fall -> FLUSH (a dl_wr in that same cycle is still pushed).
//   FLUSH: empty -> DONE. dl_active rise -> LOAD (flags/count cleared, FIFO kept).
//   DONE : dl_done=1 for this cycle only -> IDLE.
//  dl_busy = (state!=IDLE & state!=DONE).
//  dl_wr in IDLE/DONE ignored (no flag). Core never stalled; download may starve only
//   while cpu_ce is held continuously.
// STRUCTURE
//  Package atom_mem_pkg: state enum (IDLE/LOAD/FLUSH/DONE), SLOT7 base/size constants,
//   rom_page() function on 6-bit page index.
//  Sub-module atom_dl_fifo: sync FIFO {12b offset, 8b data}, push/pop/full/empty,
//   registered pointers, first-word-fall-through head. Rest (FSM, mux, flags) in top.
// TESTING
//  1 Core-only: wp_en=1, cpu write 0x55 @18'h0C010 then @18'h01000 -> mem_we=0 then 1;
//    readback of 0x01000 returns 0x55 next cycle.
//  2 Download 16 bytes 0x00..0x0F, cpu_ce=0 -> spram 0x17000..0x1700F hold data,
//    dl_count=16, one dl_done pulse, dl_overflow=dl_oor=0.
//  3 cpu_ce held 1 while 6 bytes streamed (FIFO_DEPTH=4) -> bytes 5,6 dropped,
//    dl_overflow=1; release cpu_ce -> 4 bytes written, dl_count=4.
//  4 dl_addr=25'h1000 -> no write, dl_oor=1; next download start clears it.
//  5 dl_wr on cycle dl_active falls, then cpu_ce=1 for 10 cycles -> stays FLUSH,
//    dl_busy=1; cpu_ce=0 -> byte written, then dl_done pulse.
//  6 reset asserted with 3 bytes buffered -> no further mem_we from download,
//    dl_busy=0, dl_count=0, FSM IDLE.

Source files
------------

// File: rtl/atom_mem_pkg.sv
// Shared types and constants for the Atom spram arbiter: download FSM states,
// slot-7 placement and the ROM page write-protect map.
package atom_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } dl_state_t;

    localparam logic [17:0] SLOT7_BASE = 18'h17000;
    localparam int          SLOT7_SIZE = 4096;
    localparam int          OFF_W      = 12;

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        logic [7:0]       data;
    } dl_entry_t;

    // 4 KB page index (addr[17:12]) -> page holds ROM image
    function automatic logic rom_page(input logic [5:0] page);
        return page inside {[6'h0C:6'h16], [6'h18:6'h1F], 6'h26, 6'h27, 6'h2A, [6'h2C:6'h2F]};
    endfunction

endpackage

// File: rtl/atom_dl_fifo.sv
// Small synchronous FIFO for download bytes; head is visible combinationally
// (first-word-fall-through) so a pop can drive the spram in the same cycle.
module atom_dl_fifo
    import atom_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  dl_entry_t wdata,
    output dl_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    dl_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra MSB on each pointer separates full from empty when the indices match
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/atom_mem_arbiter.sv
// Shares the single spram port between the Atom core (always wins, no added
// latency) and buffered HPS download writes into utility slot 7.
module atom_mem_arbiter
    import atom_mem_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [17:0] SLOT_BASE  = SLOT7_BASE,
    parameter int          SLOT_SIZE  = SLOT7_SIZE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        wp_en,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_q,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        dl_overflow,
    output logic        dl_oor,
    output logic [12:0] dl_count
);

    localparam logic [12:0] CNT_MAX = 13'(SLOT_SIZE);

    dl_state_t state, state_nxt;
    logic      dl_active_q;
    logic      dl_rise, dl_fall;
    logic      in_range, push, pop, clr;
    logic      fifo_full, fifo_empty;
    dl_entry_t fifo_wdata, fifo_head;

    assign dl_rise  = dl_active & ~dl_active_q;
    assign dl_fall  = ~dl_active & dl_active_q;
    assign in_range = dl_addr < 25'(SLOT_SIZE);

    // Download only uses cycles the core leaves free; nothing issued during reset
    assign pop  = ~reset & ~cpu_ce & ~fifo_empty & ((state == ST_LOAD) | (state == ST_FLUSH));
    assign push = dl_wr & (state == ST_LOAD) & in_range & (~fifo_full | pop);

    assign fifo_wdata = '{offset: dl_addr[OFF_W-1:0], data: dl_data};

    atom_dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (fifo_wdata),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_nxt = ST_LOAD;
                    clr       = 1'b1;
                end
            end
            ST_LOAD: begin
                if (dl_fall) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // A new download restarts status but keeps bytes still queued
                if (dl_rise) begin
                    state_nxt = ST_LOAD;
                    clr       = 1'b1;
                end else if (fifo_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= ST_IDLE;
            dl_active_q <= 1'b0;
            dl_overflow <= 1'b0;
            dl_oor      <= 1'b0;
            dl_count    <= '0;
        end else begin
            state       <= state_nxt;
            dl_active_q <= dl_active;
            if (clr) begin
                dl_overflow <= 1'b0;
                dl_oor      <= 1'b0;
                dl_count    <= '0;
            end else begin
                if (dl_wr && state == ST_LOAD) begin
                    if (!in_range)              dl_oor      <= 1'b1;
                    else if (fifo_full && !pop) dl_overflow <= 1'b1;
                end
                if (pop && dl_count != CNT_MAX) dl_count <= dl_count + 13'd1;
            end
        end
    end

    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
        mem_we   = 1'b0;
        if (cpu_ce) begin
            mem_we = cpu_we & ~(wp_en & rom_page(cpu_addr[17:12]));
        end else if (pop) begin
            mem_addr = SLOT_BASE + 18'(fifo_head.offset);
            mem_din  = fifo_head.data;
            mem_we   = 1'b1;
        end
    end

    assign cpu_rdata = mem_q;
    assign dl_busy   = (state == ST_LOAD) | (state == ST_FLUSH);
    assign dl_done   = (state == ST_DONE);

endmodule
